// File: rtl/jtag_host_if.sv
// Command/response channel of the JTAG host: a valid/ready command port
// plus a one-cycle response strobe carrying the captured TDO bits.
interface jtag_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_host.sv
// JTAG initiator: turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands into
// TCK/TMS/TDI sequences, captures TDO and always leaves the TAP in Run-Test/Idle.
module jtag_host #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    jtag_host_if.slave cmd,
    output logic       tck,
    output logic       tms,
    output logic       tdi,
    input  logic       tdo,
    output logic       trst_n_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

    localparam logic [1:0] OP_RESET    = 2'b00;
    localparam logic [1:0] OP_SHIFT_IR = 2'b01;
    localparam logic [1:0] OP_SHIFT_DR = 2'b10;
    localparam logic [1:0] OP_IDLE     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    op_q, op_d;
    logic [4:0]    len_q, len_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   cap_q, cap_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          tck_q, tck_d;
    logic          tms_q, tms_d;
    logic          tdi_q, tdi_d;
    logic          trst_n_q, trst_n_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          view_tlr_q, view_tlr_d;

    // Next TCK slot to start (or completion) decided at a TCK boundary.
    logic          ld;
    logic          ld_done;
    state_t        ld_state;
    logic [2:0]    ld_idx;
    logic [5:0]    ld_cnt;
    logic [4:0]    k;

    function automatic logic [2:0] pre_len(input logic [1:0] op);
        case (op)
            OP_RESET:    return 3'd6;
            OP_SHIFT_IR: return 3'd4;
            OP_SHIFT_DR: return 3'd3;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic slot_tms(input state_t st, input logic [2:0] idx,
                                      input logic [5:0] cnt, input logic [1:0] op);
        case (st)
            S_PRE: begin
                case (op)
                    OP_RESET:    return idx != 3'd5;
                    OP_SHIFT_IR: return idx < 3'd2;
                    OP_SHIFT_DR: return idx == 3'd0;
                    default:     return 1'b0;
                endcase
            end
            S_SHIFT: return (op != OP_IDLE) && (cnt == 6'd1);
            S_POST:  return idx == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Shift TCK k carries data[k]; k is recovered from the remaining-bit count.
    function automatic logic slot_tdi(input state_t st, input logic [4:0] cnt_lo,
                                      input logic [1:0] op, input logic [4:0] len,
                                      input logic [31:0] data);
        if (st == S_SHIFT && op != OP_IDLE)
            return data[len - (cnt_lo - 5'd1)];
        return 1'b0;
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        bit_cnt_d   = bit_cnt_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_n_d    = trst_n_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        view_tlr_d  = view_tlr_q;
        ld          = 1'b0;
        ld_done     = 1'b0;
        ld_state    = S_IDLE;
        ld_idx      = 3'd0;
        ld_cnt      = 6'd0;
        k           = len_q - (bit_cnt_q[4:0] - 5'd1);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d     = S_IDLE;
                trst_n_d    = 1'b1;
                cmd_ready_d = 1'b1;
                if (cmd.cmd_valid && cmd_ready_q) begin
                    op_d        = cmd.cmd_op;
                    len_d       = cmd.cmd_len;
                    data_d      = cmd.cmd_data;
                    cap_d       = '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    view_tlr_d  = 1'b0;
                    ld          = 1'b1;
                    if (view_tlr_q && cmd.cmd_op != OP_RESET) begin
                        ld_state = S_PREFIX;
                    end else if (cmd.cmd_op == OP_IDLE) begin
                        ld_state = S_SHIFT;
                        ld_cnt   = {1'b0, cmd.cmd_len} + 6'd1;
                    end else begin
                        ld_state = S_PRE;
                    end
                end
            end
            default: begin
                if (phase_q != PHASE_LAST) begin
                    phase_d = phase_q + PW'(1);
                end else if (!tck_q) begin
                    // Rising edge: tdo is sampled in the same cycle tck goes high.
                    phase_d = '0;
                    tck_d   = 1'b1;
                    if (state_q == S_SHIFT && op_q != OP_IDLE)
                        cap_d[k] = tdo;
                end else begin
                    ld = 1'b1;
                    case (state_q)
                        S_PREFIX: begin
                            if (op_q == OP_IDLE) begin
                                ld_state = S_SHIFT;
                                ld_cnt   = {1'b0, len_q} + 6'd1;
                            end else begin
                                ld_state = S_PRE;
                            end
                        end
                        S_PRE: begin
                            if (idx_q + 3'd1 < pre_len(op_q)) begin
                                ld_state = S_PRE;
                                ld_idx   = idx_q + 3'd1;
                            end else if (op_q == OP_RESET) begin
                                ld_done = 1'b1;
                            end else begin
                                ld_state = S_SHIFT;
                                ld_cnt   = {1'b0, len_q} + 6'd1;
                            end
                        end
                        S_SHIFT: begin
                            if (bit_cnt_q != 6'd1) begin
                                ld_state = S_SHIFT;
                                ld_cnt   = bit_cnt_q - 6'd1;
                            end else if (op_q == OP_IDLE) begin
                                ld_done = 1'b1;
                            end else begin
                                ld_state = S_POST;
                            end
                        end
                        S_POST: begin
                            if (idx_q == 3'd0) begin
                                ld_state = S_POST;
                                ld_idx   = 3'd1;
                            end else begin
                                ld_done = 1'b1;
                            end
                        end
                        default: ld_done = 1'b1;
                    endcase
                end
            end
        endcase

        if (ld) begin
            phase_d = '0;
            tck_d   = 1'b0;
            if (ld_done) begin
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cap_q;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                trst_n_d    = 1'b1;
            end else begin
                state_d   = ld_state;
                idx_d     = ld_idx;
                bit_cnt_d = ld_cnt;
                tms_d     = slot_tms(ld_state, ld_idx, ld_cnt, op_d);
                tdi_d     = slot_tdi(ld_state, ld_cnt[4:0], op_d, len_d, data_d);
                trst_n_d  = !(op_d == OP_RESET && ld_state == S_PRE && ld_idx == 3'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            idx_q       <= '0;
            bit_cnt_q   <= '0;
            op_q        <= OP_RESET;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_n_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            view_tlr_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            bit_cnt_q   <= bit_cnt_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_n_q    <= trst_n_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            view_tlr_q  <= view_tlr_d;
        end
    end

    assign tck           = tck_q;
    assign tms           = tms_q;
    assign tdi           = tdi_q;
    assign trst_n_o      = trst_n_q;
    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.busy      = busy_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: one instance at DIV=1 and one at DIV=3, each command
// compared against a TCK-level list of expected TMS/TDI built from the op rules.
module tb_jtag_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cmd_valid_v;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        tdo;
    logic        tck1, tms1, tdi1, trst1;
    logic        tck3, tms3, tdi3, trst3;

    always #5 clk = ~clk;

    jtag_host_if if1 ();
    jtag_host_if if3 ();

    assign if1.cmd_valid = cmd_valid_v[0];
    assign if1.cmd_op    = cmd_op;
    assign if1.cmd_len   = cmd_len;
    assign if1.cmd_data  = cmd_data;
    assign if3.cmd_valid = cmd_valid_v[1];
    assign if3.cmd_op    = cmd_op;
    assign if3.cmd_len   = cmd_len;
    assign if3.cmd_data  = cmd_data;

    jtag_host #(.DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd(if1),
        .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo), .trst_n_o(trst1)
    );

    jtag_host #(.DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd(if3),
        .tck(tck3), .tms(tms3), .tdi(tdi3), .tdo(tdo), .trst_n_o(trst3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Selected-DUT snapshot
    logic        s_tck, s_tms, s_tdi, s_trst, s_ready, s_busy, s_rsp_valid;
    logic [31:0] s_rsp_data;

    // Expected behaviour of one command
    bit          exp_tlr [2];
    logic [63:0] e_tms, e_tdi;
    int          e_cnt, e_ss, e_n;
    logic [31:0] e_rsp, e_pat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 1) begin
            s_tck = tck3; s_tms = tms3; s_tdi = tdi3; s_trst = trst3;
            s_ready = if3.cmd_ready; s_busy = if3.busy;
            s_rsp_valid = if3.rsp_valid; s_rsp_data = if3.rsp_data;
        end else begin
            s_tck = tck1; s_tms = tms1; s_tdi = tdi1; s_trst = trst1;
            s_ready = if1.cmd_ready; s_busy = if1.busy;
            s_rsp_valid = if1.rsp_valid; s_rsp_data = if1.rsp_data;
        end
    endtask

    task automatic push(input bit m, input bit d);
        e_tms[e_cnt] = m;
        e_tdi[e_cnt] = d;
        e_cnt++;
    endtask

    task automatic push_shift(input logic [31:0] data);
        e_ss = e_cnt;
        for (int i = 0; i < e_n; i++) push(i == e_n - 1, data[i]);
    endtask

    task automatic build_exp(input int sel, input logic [1:0] op, input logic [4:0] len,
                             input logic [31:0] data, input logic [31:0] pat);
        e_cnt = 0; e_tms = '0; e_tdi = '0; e_rsp = '0; e_ss = -1;
        e_n = int'(len) + 1;
        e_pat = pat;
        if (exp_tlr[sel] && op != 2'b00) push(1'b0, 1'b0);
        case (op)
            2'b00: for (int i = 0; i < 6; i++) push(i < 5, 1'b0);
            2'b01: begin
                push(1, 0); push(1, 0); push(0, 0); push(0, 0);
                push_shift(data);
                push(1, 0); push(0, 0);
            end
            2'b10: begin
                push(1, 0); push(0, 0); push(0, 0);
                push_shift(data);
                push(1, 0); push(0, 0);
            end
            default: for (int i = 0; i < e_n; i++) push(1'b0, 1'b0);
        endcase
        if (op == 2'b01 || op == 2'b10)
            for (int i = 0; i < e_n; i++) e_rsp[i] = pat[i];
    endtask

    // Target side: pattern bits during the shift window, random noise elsewhere.
    task automatic set_tdo(input int r);
        if (e_ss >= 0 && r >= e_ss && r < e_ss + e_n) tdo = e_pat[r - e_ss];
        else tdo = 1'($urandom_range(0, 1));
    endtask

    task automatic run_cmd(input int sel, input logic [1:0] op, input logic [4:0] len,
                           input logic [31:0] data, input logic [31:0] pat,
                           input bit keep, input bit b2b, input string name);
        int div, rise, cyc, run, rmin, rmax, trst_lo, ready_hi, busy_lo, first_rise;
        logic [63:0] o_tms, o_tdi;
        bit prev, done;
        div = (sel == 1) ? 3 : 1;
        build_exp(sel, op, len, data, pat);
        sample(sel);
        cyc = 0;
        while (!s_ready && cyc < 40) begin
            @(negedge clk); sample(sel); cyc++;
        end
        check({name, "_ready"}, 64'(s_ready), 64'd1);
        if (b2b) check({name, "_accept_in_rsp_cycle"}, 64'(s_rsp_valid), 64'd1);
        cmd_op = op; cmd_len = len; cmd_data = data;
        cmd_valid_v = (sel == 1) ? 2'b10 : 2'b01;
        set_tdo(0);
        @(negedge clk);
        if (!keep) cmd_valid_v = 2'b00;
        sample(sel);
        check({name, "_rsp_pulse_width"}, 64'(s_rsp_valid), 64'd0);
        o_tms = '0; o_tdi = '0; rise = 0; prev = 1'b0; run = 0;
        rmin = 1000; rmax = 0; trst_lo = 0; ready_hi = 0; busy_lo = 0;
        first_rise = -1; cyc = 1; done = 1'b0;
        while (cyc < 400) begin
            if (s_rsp_valid) begin
                done = 1'b1;
                break;
            end
            if (s_ready) ready_hi++;
            if (!s_busy) busy_lo++;
            if (!s_trst) trst_lo++;
            if (s_tck != prev) begin
                if (run > 0) begin
                    if (run < rmin) rmin = run;
                    if (run > rmax) rmax = run;
                end
                run = 1;
            end else begin
                run++;
            end
            if (s_tck && !prev) begin
                if (rise < 64) begin
                    o_tms[rise] = s_tms;
                    o_tdi[rise] = s_tdi;
                end
                if (rise == 0) first_rise = cyc;
                rise++;
                set_tdo(rise);
            end
            prev = s_tck;
            @(negedge clk); sample(sel); cyc++;
        end
        if (run < rmin) rmin = run;
        if (run > rmax) rmax = run;
        check({name, "_completed"}, 64'(done), 64'd1);
        check({name, "_tck_low_at_done"}, 64'(s_tck), 64'd0);
        check({name, "_tck_count"}, 64'(rise), 64'(e_cnt));
        check({name, "_tms_seq"}, o_tms, e_tms);
        check({name, "_tdi_seq"}, o_tdi, e_tdi);
        check({name, "_rsp_data"}, 64'(s_rsp_data), 64'(e_rsp));
        check({name, "_ready_low"}, 64'(ready_hi), 64'd0);
        check({name, "_busy_high"}, 64'(busy_lo), 64'd0);
        check({name, "_trst_low_cycles"}, 64'(trst_lo), (op == 2'b00) ? 64'(2 * div) : 64'd0);
        check({name, "_phase_min"}, 64'(rmin), 64'(div));
        check({name, "_phase_max"}, 64'(rmax), 64'(div));
        check({name, "_first_rise_delay"}, 64'(first_rise - 1), 64'(div));
        exp_tlr[sel] = 1'b0;
        $display("cmd %s: div=%0d op=%0d len=%0d tcks=%0d rsp=%08h", name, div, op, len, rise, s_rsp_data);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [4:0]  r_len;
        int          r_sel;
        rst_n = 1'b0;
        cmd_valid_v = 2'b00;
        cmd_op = 2'b00; cmd_len = '0; cmd_data = '0; tdo = 1'b0;
        exp_tlr[0] = 1'b1; exp_tlr[1] = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s);
            check($sformatf("reset%0d_tck", s), 64'(s_tck), 64'd0);
            check($sformatf("reset%0d_tms", s), 64'(s_tms), 64'd1);
            check($sformatf("reset%0d_tdi", s), 64'(s_tdi), 64'd0);
            check($sformatf("reset%0d_trst", s), 64'(s_trst), 64'd0);
            check($sformatf("reset%0d_ready", s), 64'(s_ready), 64'd0);
            check($sformatf("reset%0d_busy", s), 64'(s_busy), 64'd0);
            check($sformatf("reset%0d_rsp_valid", s), 64'(s_rsp_valid), 64'd0);
            check($sformatf("reset%0d_rsp_data", s), 64'(s_rsp_data), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s);
            check($sformatf("release%0d_trst", s), 64'(s_trst), 64'd1);
            check($sformatf("release%0d_ready", s), 64'(s_ready), 64'd1);
        end

        run_cmd(0, 2'b01, 5'd3, 32'h0000_000E, $urandom, 1'b0, 1'b0, "ir4_prefix");
        run_cmd(0, 2'b10, 5'd31, $urandom, 32'h000F_AF01, 1'b0, 1'b0, "dr32_idcode");
        run_cmd(1, 2'b00, 5'd0, 32'h0, $urandom, 1'b0, 1'b0, "reset_div3");
        run_cmd(1, 2'b11, 5'd9, 32'h0, $urandom, 1'b1, 1'b0, "idle10_held");
        run_cmd(1, 2'b10, 5'd7, $urandom, $urandom, 1'b0, 1'b1, "dr8_b2b");
        run_cmd(0, 2'b10, 5'd0, 32'h0, 32'h1, 1'b0, 1'b0, "dr1_tdo1");

        for (int i = 0; i < 8; i++) begin
            r_sel = $urandom_range(0, 1);
            r_op  = 2'($urandom_range(0, 3));
            r_len = 5'($urandom_range(0, 31));
            run_cmd(r_sel, r_op, r_len, $urandom, $urandom, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        // Abort a SHIFT_DR part way through
        sample(0);
        check("abort_ready", 64'(s_ready), 64'd1);
        cmd_op = 2'b10; cmd_len = 5'd15; cmd_data = $urandom;
        cmd_valid_v = 2'b01;
        @(negedge clk);
        cmd_valid_v = 2'b00;
        repeat (8) @(negedge clk);
        sample(0);
        check("abort_busy_before", 64'(s_busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        sample(0);
        check("abort_tck", 64'(s_tck), 64'd0);
        check("abort_tms", 64'(s_tms), 64'd1);
        check("abort_trst", 64'(s_trst), 64'd0);
        check("abort_busy", 64'(s_busy), 64'd0);
        check("abort_rsp_valid", 64'(s_rsp_valid), 64'd0);
        rst_n = 1'b1;
        exp_tlr[0] = 1'b1; exp_tlr[1] = 1'b1;
        $display("cmd abort: SHIFT_DR interrupted by rst_n");
        @(negedge clk);
        run_cmd(0, 2'b10, 5'd4, $urandom, $urandom, 1'b0, 1'b0, "dr5_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
